rs232_tx_stream: RTL



---
 rtl/rs232_tx_stream.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rs232_tx_stream.sv
// 8N1 serial transmitter fed by a 32-bit stb/ack stream through a small FIFO.
// Only the low byte of each accepted word is sent, LSB first, at CLOCK_FREQUENCY/BAUD_RATE cycles per bit.
module rs232_tx_stream #(
    parameter int CLOCK_FREQUENCY = 100000000,
    parameter int BAUD_RATE       = 115200,
    parameter int DEPTH           = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_in,
    input  logic        input_in_stb,
    output logic        input_in_ack,
    output logic        tx,
    output logic        busy,
    output logic [1:0]  dbg_state_o
);

    localparam int DIVIDER = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int TW      = $clog2(DIVIDER);
    localparam int PW      = $clog2(DEPTH);
    localparam int CW      = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Handshake: a word moves on every rising edge where input_in_stb and input_in_ack are
    // both high; the producer keeps stb and data stable until then, ack drops on that same edge.
    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            ack_q, ack_d;

    logic [7:0]      mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d, occ_after_pop;

    logic            push, pop, fifo_nonempty, bit_end;
    logic [23:0]     unused_upper;

    assign unused_upper = input_in[31:8];

    always_comb begin
        fifo_nonempty = (count_q != '0);
        bit_end       = (timer_q == TW'(DIVIDER - 1));
        push          = input_in_stb && ack_q;
        pop           = fifo_nonempty && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
        occ_after_pop = count_q - CW'(pop);
        ack_d         = !ack_q && input_in_stb && (occ_after_pop < CW'(DEPTH));
        count_d       = count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        state_d = state_q;
        timer_d = bit_end ? '0 : timer_q + TW'(1);
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (fifo_nonempty) state_d = START;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            STOP: begin
                // Chain straight into the next start bit when a word is waiting.
                if (bit_end) state_d = fifo_nonempty ? START : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The line level follows the current state one cycle later so tx comes straight from a flop.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[idx_q];
            default: tx_d = 1'b1;
        endcase
        busy_d = fifo_nonempty || (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            if (pop) shift_q <= mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            ack_q   <= ack_d;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_ptr_q] <= input_in[7:0];
    end

    assign tx           = tx_q;
    assign input_in_ack = ack_q;
    assign busy         = busy_q;
    assign dbg_state_o  = state_q;

endmodule
